// File: rtl/calc3_pkg.sv
// Shared response-path definitions: resp codes, field widths and the 36-bit queue entry.
package calc3_pkg;

    localparam int RESP_W = 2;
    localparam int TAG_W  = 2;
    localparam int DATA_W = 32;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'b00;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'b01;
    localparam logic [RESP_W-1:0] RESP_OVF  = 2'b10;
    localparam logic [RESP_W-1:0] RESP_INV  = 2'b11;

    typedef struct packed {
        logic [RESP_W-1:0] resp;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    function automatic logic resp_valid(input logic [RESP_W-1:0] r);
        return r != RESP_NONE;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Response storage: DEPTH-entry circular buffer with two ordered write ports and one read port.
module resp_fifo
    import calc3_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       c_clk,
    input  logic       reset,
    input  logic       i_wr0_en,
    input  entry_t     i_wr0_data,
    input  logic       i_wr1_en,
    input  entry_t     i_wr1_data,
    input  logic       i_rd_en,
    output entry_t     o_rd_data,
    output logic [3:0] o_count
);

    localparam int PW = $clog2(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [3:0]      r_count;

    logic [PW-1:0]   w_wr1_idx;
    logic [1:0]      w_nwr;

    // Port 1 lands right behind port 0 so same-edge arrivals keep their order.
    assign w_wr1_idx = i_wr0_en ? r_wptr + PW'(1) : r_wptr;
    assign w_nwr     = {1'b0, i_wr0_en} + {1'b0, i_wr1_en};

    always_ff @(negedge c_clk) begin
        if (!reset) begin
            if (i_wr0_en) r_mem[r_wptr]    <= i_wr0_data;
            if (i_wr1_en) r_mem[w_wr1_idx] <= i_wr1_data;
        end
    end

    always_ff @(negedge c_clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_nwr);
            if (i_rd_en) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + {2'b00, w_nwr} - {3'b000, i_rd_en};
        end
    end

    assign o_rd_data = r_mem[r_rptr];
    assign o_count   = r_count;

endmodule

// File: rtl/resp_outq.sv
// Response output queue: merges adder/shifter completions, one response per falling edge.
// Optional RESP_OUTQ_BYPASS_EN sends a lone arrival at an empty queue straight to the outputs.
module resp_outq
    import calc3_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [RESP_W-1:0] add_resp,
    input  logic [TAG_W-1:0]  add_tag,
    input  logic [DATA_W-1:0] add_data,
    input  logic [RESP_W-1:0] shf_resp,
    input  logic [TAG_W-1:0]  shf_tag,
    input  logic [DATA_W-1:0] shf_data,
    output logic [RESP_W-1:0] out_resp,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data,
    output logic              q_stall,
    output logic              q_ovf,
    output logic [3:0]        q_count
);

    entry_t     w_add, w_shf, w_head, w_byp_ent, w_c0, w_c1;
    logic       w_add_v, w_shf_v, w_deq, w_byp_ok, w_byp;
    logic       w_c0_v, w_c1_v, w_acc0, w_acc1, w_drop;
    logic [3:0] w_count, w_free;

    entry_t     r_out;
    logic       r_ovf;

    assign w_add   = '{resp: add_resp, tag: add_tag, data: add_data};
    assign w_shf   = '{resp: shf_resp, tag: shf_tag, data: shf_data};
    assign w_add_v = resp_valid(add_resp);
    assign w_shf_v = resp_valid(shf_resp);

`ifdef RESP_OUTQ_BYPASS_EN
    assign w_byp_ok = 1'b1;
`else
    assign w_byp_ok = 1'b0;
`endif

    assign w_deq  = (w_count != 4'd0);
    // The slot vacated by this edge's dequeue is available to this edge's arrivals.
    assign w_free = 4'(DEPTH) - w_count + {3'b000, w_deq};

    always_comb begin
        w_byp     = 1'b0;
        w_byp_ent = '0;
        w_c0_v    = 1'b0;
        w_c0      = '0;
        w_c1_v    = 1'b0;
        w_c1      = '0;
        if (w_byp_ok && (w_count == 4'd0) && (w_add_v || w_shf_v)) begin
            w_byp     = 1'b1;
            w_byp_ent = w_add_v ? w_add : w_shf;
            w_c0_v    = w_add_v && w_shf_v;
            w_c0      = w_shf;
        end else if (w_add_v) begin
            w_c0_v = 1'b1;
            w_c0   = w_add;
            w_c1_v = w_shf_v;
            w_c1   = w_shf;
        end else begin
            w_c0_v = w_shf_v;
            w_c0   = w_shf;
        end
    end

    // Candidate 1 is always the shifter, so it is the one dropped when space runs short.
    assign w_acc0 = w_c0_v && (w_free >= 4'd1);
    assign w_acc1 = w_c1_v && (w_free >= 4'd2);
    assign w_drop = (w_c0_v && !w_acc0) || (w_c1_v && !w_acc1);

    resp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .c_clk      (c_clk),
        .reset      (reset),
        .i_wr0_en   (w_acc0),
        .i_wr0_data (w_c0),
        .i_wr1_en   (w_acc1),
        .i_wr1_data (w_c1),
        .i_rd_en    (w_deq),
        .o_rd_data  (w_head),
        .o_count    (w_count)
    );

    always_ff @(negedge c_clk) begin
        if (reset) begin
            r_out <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_deq)      r_out <= w_head;
            else if (w_byp) r_out <= w_byp_ent;
            else            r_out <= '0;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign out_resp = r_out.resp;
    assign out_tag  = r_out.tag;
    assign out_data = r_out.data;
    assign q_ovf    = r_ovf;
    assign q_count  = w_count;
    assign q_stall  = (w_count >= 4'(DEPTH - 1));

endmodule

// File: tb/tb_resp_outq.sv
// Directed bench for resp_outq (DEPTH=4, default build): latency, ordering, stall, overflow, reset, wrap.
module tb_resp_outq;

  logic        c_clk = 1'b1;
  logic        reset;
  logic [1:0]  add_resp, add_tag, shf_resp, shf_tag;
  logic [31:0] add_data, shf_data;
  logic [1:0]  out_resp, out_tag;
  logic [31:0] out_data;
  logic        q_stall, q_ovf;
  logic [3:0]  q_count;

  int checks = 0;
  int errors = 0;

  resp_outq #(.DEPTH(4)) dut (
    .c_clk    (c_clk),
    .reset    (reset),
    .add_resp (add_resp),
    .add_tag  (add_tag),
    .add_data (add_data),
    .shf_resp (shf_resp),
    .shf_tag  (shf_tag),
    .shf_data (shf_data),
    .out_resp (out_resp),
    .out_tag  (out_tag),
    .out_data (out_data),
    .q_stall  (q_stall),
    .q_ovf    (q_ovf),
    .q_count  (q_count)
  );

  always #5 c_clk = ~c_clk;

  // One active (falling) edge, then return to the rising edge to sample and drive.
  task automatic step();
    @(negedge c_clk);
    @(posedge c_clk);
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] ent(input logic [1:0] r, input logic [1:0] t, input logic [31:0] d);
    return {r, t, d};
  endfunction

  function automatic logic [35:0] outw();
    return {out_resp, out_tag, out_data};
  endfunction

  task automatic drv_add(input logic [1:0] r, input logic [1:0] t, input logic [31:0] d);
    add_resp = r; add_tag = t; add_data = d;
  endtask

  task automatic drv_shf(input logic [1:0] r, input logic [1:0] t, input logic [31:0] d);
    shf_resp = r; shf_tag = t; shf_data = d;
  endtask

  task automatic idle();
    drv_add(2'b00, 2'd0, 32'd0);
    drv_shf(2'b00, 2'd0, 32'd0);
  endtask

  logic [35:0] ph_out [9];
  logic [3:0]  ph_cnt [9];
  logic        ph_stl [9];
  logic        ph_ovf [9];

  initial begin
    reset = 1'b1;
    idle();

    // Reset state
    step();
    step();
    chk("rst_count", 36'(q_count), 36'd0);
    chk("rst_flags", {34'd0, q_stall, q_ovf}, 36'd0);
    chk("rst_out", outw(), 36'd0);
    reset = 1'b0;
    step();
    chk("post_rst_out", outw(), 36'd0);

    // Single add: two-edge latency, one-cycle pulse
    drv_add(2'b01, 2'd2, 32'h0000_0005);
    step();
    idle();
    chk("single_e1_out", outw(), 36'd0);
    chk("single_e1_cnt", 36'(q_count), 36'd1);
    step();
    chk("single_e2_out", outw(), ent(2'b01, 2'd2, 32'h5));
    chk("single_e2_cnt", 36'(q_count), 36'd0);
    step();
    chk("single_pulse_end", outw(), 36'd0);

    // Dual arrival: adder first, then shifter; codes pass through
    drv_add(2'b01, 2'd0, 32'hA);
    drv_shf(2'b10, 2'd1, 32'hB);
    step();
    idle();
    chk("dual_e1_cnt", 36'(q_count), 36'd2);
    chk("dual_e1_out", outw(), 36'd0);
    step();
    chk("dual_e2_out", outw(), ent(2'b01, 2'd0, 32'hA));
    step();
    chk("dual_e3_out", outw(), ent(2'b10, 2'd1, 32'hB));
    step();
    chk("dual_e4_out", outw(), 36'd0);

    // Fill / stall / overflow: dual arrivals on four consecutive edges, then drain
    ph_out = '{36'd0,
               ent(2'b01, 2'd0, 32'hA0), ent(2'b11, 2'd0, 32'hB0),
               ent(2'b01, 2'd1, 32'hA1), ent(2'b11, 2'd1, 32'hB1),
               ent(2'b01, 2'd2, 32'hA2), ent(2'b11, 2'd2, 32'hB2),
               ent(2'b01, 2'd3, 32'hA3), 36'd0};
    ph_cnt = '{4'd2, 4'd3, 4'd4, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    ph_stl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ph_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 9; k++) begin
      if (k < 4) begin
        drv_add(2'b01, 2'(k), 32'hA0 + 32'(k));
        drv_shf(2'b11, 2'(k), 32'hB0 + 32'(k));
      end else begin
        idle();
      end
      step();
      chk($sformatf("fill_out_e%0d", k), outw(), ph_out[k]);
      chk($sformatf("fill_cnt_e%0d", k), 36'(q_count), 36'(ph_cnt[k]));
      chk($sformatf("fill_stall_e%0d", k), 36'(q_stall), 36'(ph_stl[k]));
      chk($sformatf("fill_ovf_e%0d", k), 36'(q_ovf), 36'(ph_ovf[k]));
    end
    idle();
    step();
    chk("ovf_sticky", 36'(q_ovf), 36'd1);

    // Reset mid-operation with q_count=3, plus a same-edge arrival
    drv_add(2'b01, 2'd1, 32'h11);
    drv_shf(2'b01, 2'd2, 32'h22);
    step();
    step();
    chk("pre_rst_cnt", 36'(q_count), 36'd3);
    chk("pre_rst_stall", 36'(q_stall), 36'd1);
    reset = 1'b1;
    drv_add(2'b01, 2'd3, 32'h33);
    idle();
    drv_add(2'b01, 2'd3, 32'h33);
    step();
    idle();
    chk("mid_rst_cnt", 36'(q_count), 36'd0);
    chk("mid_rst_out", outw(), 36'd0);
    chk("mid_rst_flags", {34'd0, q_stall, q_ovf}, 36'd0);
    reset = 1'b0;
    step();
    chk("after_rst_out0", outw(), 36'd0);
    chk("after_rst_cnt0", 36'(q_count), 36'd0);
    step();
    chk("after_rst_out1", outw(), 36'd0);

    // Pointer wrap: 12 single responses, tags 0..3 repeating
    for (int i = 0; i < 12; i++) begin
      drv_add(2'b01, 2'(i % 4), 32'h100 + 32'(i));
      step();
      if (i > 0) begin
        chk($sformatf("wrap_out_%0d", i - 1), outw(), ent(2'b01, 2'((i - 1) % 4), 32'h100 + 32'(i - 1)));
      end
      chk($sformatf("wrap_cnt_%0d", i), 36'(q_count), 36'd1);
    end
    idle();
    step();
    chk("wrap_out_11", outw(), ent(2'b01, 2'd3, 32'h10B));
    step();
    chk("wrap_end_out", outw(), 36'd0);
    chk("wrap_end_cnt", 36'(q_count), 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/resp_outq.md
RESP_OUTQ -- requirements
Module: resp_outq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; legal values 2, 4, 8.
REQ-002 SHALL have port c_clk  input  1  sole clock; all state updates on falling edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on falling edge of c_clk.
REQ-004 SHALL have ports add_resp, add_tag, add_data  input  2/2/32  adder-unit completion; nonzero resp = valid.
REQ-005 SHALL have ports shf_resp, shf_tag, shf_data  input  2/2/32  shifter-unit completion; nonzero resp = valid.
REQ-006 SHALL have ports out_resp, out_tag, out_data  output  2/2/32  port response; nonzero out_resp = one-cycle response pulse.
REQ-007 SHALL have port q_stall  output  1  tells priority dispatch to issue nothing this cycle.
REQ-008 SHALL have port q_ovf  output  1  sticky overflow error flag.
REQ-009 SHALL have port q_count  output  4  current number of occupied entries.

Function
REQ-010 SHALL treat resp codes 01 success, 10 overflow/underflow, 11 invalid command, 00 no response; codes pass through unmodified.
REQ-011 SHALL enqueue every valid input at a falling edge; max two arrivals per edge.
REQ-012 SHALL enqueue adder entry before shifter entry when both arrive at the same edge.
REQ-013 SHALL dequeue at most one entry per edge, oldest first, into output registers out_resp/out_tag/out_data.
REQ-014 SHALL drive out_resp, out_tag, out_data to all zeros in any cycle with no dequeue.
REQ-015 SHALL present a response arriving at an empty queue on the outputs after the second falling edge (enqueue edge, then dequeue edge).
REQ-016 SHALL permit simultaneous enqueue and dequeue at one edge; q_count updates by arrivals minus departures.
REQ-017 SHALL assert q_stall when free entries < 2, i.e. q_count >= DEPTH-1.
REQ-018 SHALL drop arrivals exceeding free space (shifter dropped first), never overwrite stored entries, and set q_ovf.
REQ-019 SHALL hold q_ovf at 1 until reset.
REQ-020 SHALL wrap read/write pointers modulo DEPTH without losing or duplicating entries.
REQ-021 SHALL count free space with the same-edge dequeue included when checking for overflow.

Reset
REQ-022 SHALL, at reset, clear pointers, q_count=0, q_ovf=0, q_stall=0, out_resp/out_tag/out_data=0.
REQ-023 SHALL discard in-flight entries and same-edge arrivals when reset asserts mid-operation.
REQ-024 SHALL output no response in the first cycle after reset deasserts.

Configuration
REQ-025 SHALL support macro RESP_OUTQ_BYPASS_EN.
REQ-026 With RESP_OUTQ_BYPASS_EN defined, SHALL load a single arrival at an empty queue directly into the output registers at the arrival edge (1-edge latency), without changing q_count.
REQ-027 With RESP_OUTQ_BYPASS_EN defined and both units arriving at an empty queue, SHALL bypass the adder entry and enqueue the shifter entry.
REQ-028 Without RESP_OUTQ_BYPASS_EN, SHALL apply REQ-015 latency to every response.

Structure
REQ-029 SHALL take resp-code constants, field widths and the entry typedef (resp, tag, data; 36 bits) from shared package calc3_pkg.
REQ-030 SHALL place storage, pointers and count in sub-module resp_fifo; resp_outq holds arrival ordering, output registers, stall and overflow logic.

Verification
REQ-031 Single add: add_resp=01, tag=2, data=0x0000_0005 into empty queue -> out_resp=01, tag=2, data=5 after 2nd edge (1st with bypass), for exactly one cycle.
REQ-032 Dual arrival: add (01, tag 0, 0xA) and shf (10, tag 1, 0xB) at same edge -> tag 0 output, then tag 1 on the next cycle.
REQ-033 Fill DEPTH=4 with no dequeue opportunity lost -> q_stall=1 at q_count=3; q_count never exceeds 4.
REQ-034 Dual arrivals on four consecutive edges -> q_ovf=1 and shifter entry dropped; tags of surviving outputs in order; q_ovf holds until reset.
REQ-035 Reset asserted with q_count=3 -> next cycle q_count=0, outputs zero, no stale response after deassertion.
REQ-036 Wrap: stream 12 single responses with tags 0,1,2,3 repeating -> outputs in identical order, none duplicated.
